// File: rtl/vga_timing_aot_if.sv
// Raster timing bundle produced by vga_timing_aot: beam position, syncs,
// blanking, the look-ahead coordinate stream and its strobes.
interface vga_timing_aot_if #(
   parameter int H_ADDR_WIDTH    = 10,
   parameter int V_ADDR_WIDTH    = 10,
   parameter int FRAME_CNT_WIDTH = 16
);
   logic                       pix_stb;
   logic [H_ADDR_WIDTH-1:0]    sx;
   logic [V_ADDR_WIDTH-1:0]    sy;
   logic                       display_enabled;
   logic                       H_SYNC;
   logic                       V_SYNC;
   logic [H_ADDR_WIDTH-1:0]    sx_aot;
   logic [V_ADDR_WIDTH-1:0]    sy_aot;
   logic                       display_enabled_aot;
   logic                       line_stb_aot;
   logic                       frame_stb_aot;
   logic [FRAME_CNT_WIDTH-1:0] frame_count;

   modport master (
      output pix_stb, sx, sy, display_enabled, H_SYNC, V_SYNC,
             sx_aot, sy_aot, display_enabled_aot, line_stb_aot,
             frame_stb_aot, frame_count
   );

   modport slave (
      input  pix_stb, sx, sy, display_enabled, H_SYNC, V_SYNC,
             sx_aot, sy_aot, display_enabled_aot, line_stb_aot,
             frame_stb_aot, frame_count
   );
endinterface

// File: rtl/vga_timing_aot.sv
// VGA raster timing generator with a second coordinate stream leading the beam
// by LOOKAHEAD pixels, an internal pixel-clock divider and a frame counter.
module vga_timing_aot #(
   parameter int H_VISIBLE_AREA  = 640,
   parameter int H_FRONT_PORCH   = 16,
   parameter int H_SYNC_PULSE    = 96,
   parameter int H_BACK_PORCH    = 48,
   parameter int V_VISIBLE_AREA  = 480,
   parameter int V_FRONT_PORCH   = 10,
   parameter int V_SYNC_PULSE    = 2,
   parameter int V_BACK_PORCH    = 33,
   parameter int H_SYNC_POL      = 0,
   parameter int V_SYNC_POL      = 0,
   parameter int LOOKAHEAD       = 2,
   parameter int CLK_DIV         = 1,
   parameter int FRAME_CNT_WIDTH = 16
) (
   input  logic             vga_pix_clk,
   input  logic             CPU_RESETN,
   vga_timing_aot_if.master vga
);
   localparam int H_WHOLE_LINE = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
   localparam int V_WHOLE_LINE = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
   localparam int H_ADDR_WIDTH = $clog2(H_WHOLE_LINE);
   localparam int V_ADDR_WIDTH = $clog2(V_WHOLE_LINE);
   // Decode thresholds may equal the whole line, so compare one bit wider.
   localparam int HC_W = H_ADDR_WIDTH + 1;
   localparam int VC_W = V_ADDR_WIDTH + 1;

   localparam logic [H_ADDR_WIDTH-1:0]    H_LAST     = H_ADDR_WIDTH'(H_WHOLE_LINE - 1);
   localparam logic [V_ADDR_WIDTH-1:0]    V_LAST     = V_ADDR_WIDTH'(V_WHOLE_LINE - 1);
   localparam logic [H_ADDR_WIDTH-1:0]    H_ONE      = H_ADDR_WIDTH'(1);
   localparam logic [V_ADDR_WIDTH-1:0]    V_ONE      = V_ADDR_WIDTH'(1);
   localparam logic [FRAME_CNT_WIDTH-1:0] FC_ONE     = FRAME_CNT_WIDTH'(1);
   localparam logic [H_ADDR_WIDTH-1:0]    SX_AOT_RST = H_ADDR_WIDTH'(LOOKAHEAD);
   localparam logic [HC_W-1:0] H_VIS      = HC_W'(H_VISIBLE_AREA);
   localparam logic [HC_W-1:0] H_SYNC_BEG = HC_W'(H_VISIBLE_AREA + H_FRONT_PORCH);
   localparam logic [HC_W-1:0] H_SYNC_END = HC_W'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
   localparam logic [VC_W-1:0] V_VIS      = VC_W'(V_VISIBLE_AREA);
   localparam logic [VC_W-1:0] V_SYNC_BEG = VC_W'(V_VISIBLE_AREA + V_FRONT_PORCH);
   localparam logic [VC_W-1:0] V_SYNC_END = VC_W'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);
   localparam logic H_POL = (H_SYNC_POL != 0);
   localparam logic V_POL = (V_SYNC_POL != 0);

   if (LOOKAHEAD < 0 || LOOKAHEAD >= H_WHOLE_LINE || CLK_DIV < 1) begin : g_param_check
      $error("vga_timing_aot: LOOKAHEAD must lie in 0..H_WHOLE_LINE-1 and CLK_DIV must be >= 1");
   end

   logic                       pix_stb_s;
   logic [H_ADDR_WIDTH-1:0]    sx_r;
   logic [V_ADDR_WIDTH-1:0]    sy_r;
   logic [H_ADDR_WIDTH-1:0]    sx_aot_r;
   logic [V_ADDR_WIDTH-1:0]    sy_aot_r;
   logic [FRAME_CNT_WIDTH-1:0] frame_count_r;
   logic                       frame_end_s;
   logic                       h_act_s;
   logic                       v_act_s;

   function automatic logic [H_ADDR_WIDTH-1:0] next_x(input logic [H_ADDR_WIDTH-1:0] x);
      logic [H_ADDR_WIDTH-1:0] r;
      if (x == H_LAST) r = '0;
      else             r = x + H_ONE;
      return r;
   endfunction

   function automatic logic [V_ADDR_WIDTH-1:0] next_y(input logic [H_ADDR_WIDTH-1:0] x,
                                                      input logic [V_ADDR_WIDTH-1:0] y);
      logic [V_ADDR_WIDTH-1:0] r;
      if (x != H_LAST)      r = y;
      else if (y == V_LAST) r = '0;
      else                  r = y + V_ONE;
      return r;
   endfunction

   if (CLK_DIV <= 1) begin : g_no_div
      assign pix_stb_s = 1'b1;
   end else begin : g_div
      localparam int DIV_W = $clog2(CLK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
      localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
      logic [DIV_W-1:0] div_cnt_r;

      // Pixel-clock divider: counts 0..CLK_DIV-1 and wraps.
      always_ff @(posedge vga_pix_clk or negedge CPU_RESETN) begin
         if (!CPU_RESETN)               div_cnt_r <= '0;
         else if (div_cnt_r == DIV_LAST) div_cnt_r <= '0;
         else                           div_cnt_r <= div_cnt_r + DIV_ONE;
      end

      assign pix_stb_s = (div_cnt_r == DIV_LAST);
   end

   assign frame_end_s = pix_stb_s && (sx_r == H_LAST) && (sy_r == V_LAST);

   // Beam and look-ahead counters advance together, so their offset never drifts.
   always_ff @(posedge vga_pix_clk or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         sx_r          <= '0;
         sy_r          <= '0;
         sx_aot_r      <= SX_AOT_RST;
         sy_aot_r      <= '0;
         frame_count_r <= '0;
      end else if (pix_stb_s) begin
         sx_r     <= next_x(sx_r);
         sy_r     <= next_y(sx_r, sy_r);
         sx_aot_r <= next_x(sx_aot_r);
         sy_aot_r <= next_y(sx_aot_r, sy_aot_r);
         if (frame_end_s) frame_count_r <= frame_count_r + FC_ONE;
      end
   end

   assign h_act_s = ({1'b0, sx_r} >= H_SYNC_BEG) && ({1'b0, sx_r} < H_SYNC_END);
   assign v_act_s = ({1'b0, sy_r} >= V_SYNC_BEG) && ({1'b0, sy_r} < V_SYNC_END);

   assign vga.pix_stb             = pix_stb_s;
   assign vga.sx                  = sx_r;
   assign vga.sy                  = sy_r;
   assign vga.sx_aot              = sx_aot_r;
   assign vga.sy_aot              = sy_aot_r;
   assign vga.frame_count         = frame_count_r;
   assign vga.display_enabled     = ({1'b0, sx_r} < H_VIS) && ({1'b0, sy_r} < V_VIS);
   assign vga.display_enabled_aot = ({1'b0, sx_aot_r} < H_VIS) && ({1'b0, sy_aot_r} < V_VIS);
   assign vga.H_SYNC              = h_act_s ? H_POL : ~H_POL;
   assign vga.V_SYNC              = v_act_s ? V_POL : ~V_POL;
   assign vga.line_stb_aot        = pix_stb_s && (sx_aot_r == '0);
   assign vga.frame_stb_aot       = pix_stb_s && (sx_aot_r == '0) && (sy_aot_r == '0);
endmodule

// File: tb/tb_vga_timing_aot.sv
// Bench for vga_timing_aot on a shrunken raster (15x9 pixels) with three
// instances: lead 4 / div 1, lead 14 / div 3 / inverted syncs / 2-bit count, lead 0.
module tb_vga_timing_aot;
   localparam int HV = 8, HF = 2, HS = 3, HB = 2;
   localparam int VV = 4, VF = 1, VS = 2, VB = 2;
   localparam int HW = HV + HF + HS + HB;
   localparam int VW = VV + VF + VS + VB;
   localparam int TOT = HW * VW;

   typedef struct packed {
      logic [3:0]  sx;
      logic [3:0]  sy;
      logic [3:0]  sxa;
      logic [3:0]  sya;
      logic        ps;
      logic        de;
      logic        dea;
      logic        hs;
      logic        vs;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
   } obs_t;

   typedef struct {
      int c;
      int sx, sy, sxa, sya;
      bit de, dea, hs, vs, ls, fs;
      int fc;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   c = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   vga_timing_aot_if #(.H_ADDR_WIDTH(4), .V_ADDR_WIDTH(4), .FRAME_CNT_WIDTH(16)) ia ();
   vga_timing_aot_if #(.H_ADDR_WIDTH(4), .V_ADDR_WIDTH(4), .FRAME_CNT_WIDTH(2))  ib ();
   vga_timing_aot_if #(.H_ADDR_WIDTH(4), .V_ADDR_WIDTH(4), .FRAME_CNT_WIDTH(16)) ic ();

   vga_timing_aot #(
      .H_VISIBLE_AREA(HV), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(HS), .H_BACK_PORCH(HB),
      .V_VISIBLE_AREA(VV), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(VS), .V_BACK_PORCH(VB),
      .H_SYNC_POL(0), .V_SYNC_POL(0), .LOOKAHEAD(4), .CLK_DIV(1), .FRAME_CNT_WIDTH(16)
   ) dut_a (.vga_pix_clk(clk), .CPU_RESETN(rst_n), .vga(ia));

   vga_timing_aot #(
      .H_VISIBLE_AREA(HV), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(HS), .H_BACK_PORCH(HB),
      .V_VISIBLE_AREA(VV), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(VS), .V_BACK_PORCH(VB),
      .H_SYNC_POL(1), .V_SYNC_POL(1), .LOOKAHEAD(14), .CLK_DIV(3), .FRAME_CNT_WIDTH(2)
   ) dut_b (.vga_pix_clk(clk), .CPU_RESETN(rst_n), .vga(ib));

   vga_timing_aot #(
      .H_VISIBLE_AREA(HV), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(HS), .H_BACK_PORCH(HB),
      .V_VISIBLE_AREA(VV), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(VS), .V_BACK_PORCH(VB),
      .H_SYNC_POL(0), .V_SYNC_POL(0), .LOOKAHEAD(0), .CLK_DIV(1), .FRAME_CNT_WIDTH(16)
   ) dut_c (.vga_pix_clk(clk), .CPU_RESETN(rst_n), .vga(ic));

   // Closed-form reference: after cyc clock edges out of reset, n = cyc/d pixels have
   // elapsed; every output follows from the linear raster index n (+ lead) mod frame size.
   function automatic obs_t model(int cyc, int la, int d, bit hp, bit vp, int fcw);
      obs_t e;
      int n, lin, lina, bx, by, ax, ay;
      n    = cyc / d;
      lin  = n % TOT;
      lina = (n + la) % TOT;
      bx = lin % HW;   by = lin / HW;
      ax = lina % HW;  ay = lina / HW;
      e.sx  = 4'(bx);
      e.sy  = 4'(by);
      e.sxa = 4'(ax);
      e.sya = 4'(ay);
      e.ps  = ((cyc % d) == d - 1);
      e.de  = (bx < HV) && (by < VV);
      e.dea = (ax < HV) && (ay < VV);
      e.hs  = ((bx >= HV + HF) && (bx < HV + HF + HS)) ? hp : !hp;
      e.vs  = ((by >= VV + VF) && (by < VV + VF + VS)) ? vp : !vp;
      e.ls  = e.ps && (ax == 0);
      e.fs  = e.ls && (ay == 0);
      e.fc  = 16'((n / TOT) % (1 << fcw));
      return e;
   endfunction

   task automatic cmp(string tag, obs_t got, obs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s c=%0d got sx=%0d sy=%0d sxa=%0d sya=%0d ps=%b de=%b dea=%b hs=%b vs=%b ls=%b fs=%b fc=%0d | exp sx=%0d sy=%0d sxa=%0d sya=%0d ps=%b de=%b dea=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                  tag, c, got.sx, got.sy, got.sxa, got.sya, got.ps, got.de, got.dea, got.hs, got.vs,
                  got.ls, got.fs, got.fc, exp.sx, exp.sy, exp.sxa, exp.sya, exp.ps, exp.de, exp.dea,
                  exp.hs, exp.vs, exp.ls, exp.fs, exp.fc);
      end
   endtask

   function automatic obs_t obs_a();
      return {ia.sx, ia.sy, ia.sx_aot, ia.sy_aot, ia.pix_stb, ia.display_enabled,
              ia.display_enabled_aot, ia.H_SYNC, ia.V_SYNC, ia.line_stb_aot,
              ia.frame_stb_aot, ia.frame_count};
   endfunction

   task automatic check_all();
      obs_t gb, gc;
      gb = {ib.sx, ib.sy, ib.sx_aot, ib.sy_aot, ib.pix_stb, ib.display_enabled,
            ib.display_enabled_aot, ib.H_SYNC, ib.V_SYNC, ib.line_stb_aot,
            ib.frame_stb_aot, 14'd0, ib.frame_count};
      gc = {ic.sx, ic.sy, ic.sx_aot, ic.sy_aot, ic.pix_stb, ic.display_enabled,
            ic.display_enabled_aot, ic.H_SYNC, ic.V_SYNC, ic.line_stb_aot,
            ic.frame_stb_aot, ic.frame_count};
      cmp("model_a", obs_a(), model(c, 4, 1, 1'b0, 1'b0, 16));
      cmp("model_b", gb, model(c, 14, 3, 1'b1, 1'b1, 2));
      cmp("model_c", gc, model(c, 0, 1, 1'b0, 1'b0, 16));
   endtask

   // One clock: count the edge if out of reset, then check on the falling edge.
   task automatic step();
      @(posedge clk);
      if (rst_n) c = c + 1;
      @(negedge clk);
      check_all();
   endtask

   // Asynchronous reset raised between edges; its effect is checked before the next edge.
   task automatic do_reset(int hold);
      #1 rst_n = 1'b0;
      c = 0;
      #1 check_all();
      repeat (hold) step();
      #1 rst_n = 1'b1;
   endtask

   task automatic cmp_vec(string tag, vec_t v);
      obs_t e;
      e.sx = 4'(v.sx);   e.sy = 4'(v.sy);
      e.sxa = 4'(v.sxa); e.sya = 4'(v.sya);
      e.ps = 1'b1;
      e.de = v.de; e.dea = v.dea; e.hs = v.hs; e.vs = v.vs; e.ls = v.ls; e.fs = v.fs;
      e.fc = 16'(v.fc);
      cmp(tag, obs_a(), e);
   endtask

   initial begin
      vec_t tbl[10];
      //           c    sx sy sxa sya de dea hs vs ls fs fc
      tbl[0] = '{  0,   0, 0,  4,  0, 1, 1, 1, 1, 0, 0, 0};
      tbl[1] = '{  1,   1, 0,  5,  0, 1, 1, 1, 1, 0, 0, 0};
      tbl[2] = '{ 10,  10, 0, 14,  0, 0, 0, 0, 1, 0, 0, 0};
      tbl[3] = '{ 11,  11, 0,  0,  1, 0, 1, 0, 1, 1, 0, 0};
      tbl[4] = '{ 13,  13, 0,  2,  1, 0, 1, 1, 1, 0, 0, 0};
      tbl[5] = '{ 75,   0, 5,  4,  5, 0, 0, 1, 0, 0, 0, 0};
      tbl[6] = '{131,  11, 8,  0,  0, 0, 1, 0, 1, 1, 1, 0};
      tbl[7] = '{134,  14, 8,  3,  0, 0, 1, 1, 1, 0, 0, 0};
      tbl[8] = '{135,   0, 0,  4,  0, 1, 1, 1, 1, 0, 0, 1};
      tbl[9] = '{320,   5, 3,  9,  3, 1, 0, 1, 1, 0, 0, 2};

      repeat (2) step();
      #1 rst_n = 1'b1;

      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 10; i++) begin
            if (pass == 0 || tbl[i].c <= TOT) begin
               while (c < tbl[i].c) step();
               cmp_vec($sformatf("vec%0d_pass%0d", i, pass), tbl[i]);
            end
         end
         // Mid-frame abort with two frames counted; timing restarts from reset values.
         if (pass == 0) do_reset(3);
      end

      for (int s = 0; s < 10; s++) begin
         repeat ($urandom_range(30, 600)) step();
         do_reset(int'($urandom_range(1, 4)));
      end

      // Long run so the 2-bit frame counter wraps and every lead crosses frame ends.
      repeat (1800) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
